// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request and
// response channel, with a programmable number of wait states between
// request acceptance and response. Faulting requests (misaligned or out of
// range) return rsp_err and never touch the array.
//
// Handshake: a request transfers on a ce edge where req_valid && req_ready;
// a response transfers on a ce edge where rsp_valid && rsp_ready. Each side
// holds its payload stable until the transfer edge. The side that receives
// may hold ready low for as long as it likes.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    addr_q;
    logic           we_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_rdata_q;
    logic           rsp_err_q;

    logic [31:0]    mem_q [DEPTH_WORDS];

    // Effective request: live inputs while idle (needed when there are no
    // wait states and the access happens on the acceptance edge), latched
    // copy otherwise.
    logic [31:0]    eff_addr;
    logic           eff_we;
    logic [31:0]    eff_wdata;
    logic [3:0]     eff_be;
    logic           eff_fault;
    logic [AW-1:0]  eff_idx;
    logic           enter_resp;
    logic           mem_we;
    logic [31:0]    rd_word;
    logic [31:0]    rsp_rdata_d;
    logic           rsp_err_d;

    // Decode the effective request, fault status and response payload.
    always_comb begin
        eff_addr    = (state_q == S_IDLE) ? req_addr  : addr_q;
        eff_we      = (state_q == S_IDLE) ? req_we    : we_q;
        eff_wdata   = (state_q == S_IDLE) ? req_wdata : wdata_q;
        eff_be      = (state_q == S_IDLE) ? req_be    : be_q;
        eff_fault   = (eff_addr[1:0] != 2'b00) ||
                      ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
        eff_idx     = eff_addr[AW+1:2];
        enter_resp  = ((state_q == S_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == '0));
        mem_we      = ce && !reset && enter_resp && eff_we && !eff_fault;
        rd_word     = mem_q[eff_idx];
        rsp_rdata_d = (!eff_we && !eff_fault) ? rd_word : 32'h0;
        rsp_err_d   = eff_fault;
    end

    // Byte-masked store into the array; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) begin
                    mem_q[eff_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CW'(WAIT_STATES - 1);
                        end else begin
                            state_q     <= S_RESP;
                            cnt_q       <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    // Retiring edge returns to idle; the next acceptance is
                    // therefore at least one cycle later.
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table of complete transactions
// on a WAIT_STATES=2 and a WAIT_STATES=0 instance, plus hand-written
// sequences for backpressure, clock-enable stalls and reset mid-transaction.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    // instance A: DEPTH_WORDS=256, WAIT_STATES=2
    logic        a_req_valid, a_req_we, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;
    logic [1:0]  a_dbg_state;

    // instance B: DEPTH_WORDS=16, WAIT_STATES=0
    logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;
    logic [1:0]  b_dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .reset(reset), .ce(ce),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_be(a_req_be), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .dbg_state_o(a_dbg_state)
    );

    mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .reset(reset), .ce(ce),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_be(b_req_be), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .dbg_state_o(b_dbg_state)
    );

    typedef struct {
        bit          sel;        // 0 = instance A, 1 = instance B
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full transaction: wait for req_ready, present request for one edge,
    // scramble request inputs, measure latency, collect response, retire.
    task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int lat, output logic [31:0] rdata, output logic err);
        int guard;
        guard = 0;
        while (!(sel ? b_req_ready : a_req_ready) && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        if (!sel) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
        end
        tick();
        // acceptance edge has passed; later changes must be ignored
        a_req_valid = 1'b0; a_req_we = 1'($urandom_range(0, 1)); a_req_addr = $urandom;
        a_req_wdata = $urandom; a_req_be = 4'($urandom_range(0, 15));
        b_req_valid = 1'b0; b_req_we = 1'($urandom_range(0, 1)); b_req_addr = $urandom;
        b_req_wdata = $urandom; b_req_be = 4'($urandom_range(0, 15));
        lat = 1;
        while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 50) begin
            tick();
            lat++;
        end
        rdata = sel ? b_rsp_rdata : a_rsp_rdata;
        err   = sel ? b_rsp_err : a_rsp_err;
        if (!sel) a_rsp_ready = 1'b1; else b_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          guard;

        // reset while ce is low: reset must still take effect
        reset = 1'b1; ce = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 0;
        tick();
        tick();
        check("rst_a_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_a_rsp_rdata", a_rsp_rdata, 32'h0);
        check("rst_a_rsp_err", 32'(a_rsp_err), 32'd0);
        check("rst_a_state", 32'(a_dbg_state), 32'd0);
        check("rst_b_req_ready", 32'(b_req_ready), 32'd1);
        check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        reset = 1'b0; ce = 1'b1;
        tick();

        // sel we addr wdata be exp_rdata exp_err exp_lat
        vecs.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1, 3});
        vecs.push_back('{0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 3});
        vecs.push_back('{0, 1'b0, 32'h80000010, 32'h0,   4'h0, 32'h0,        1'b1, 3});
        vecs.push_back('{0, 1'b1, 32'h12,  32'h11223344, 4'hF, 32'h0,        1'b1, 3});
        vecs.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h3FC, 32'h12345678, 4'hA, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h3FC, 32'h0,        4'h0, 32'h12A556A5, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h14,  32'h01020304, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h14,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h14,  32'h0,        4'h0, 32'h01020304, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h20,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 3});
        vecs.push_back('{1, 1'b1, 32'h8,   32'h13579BDF, 4'hF, 32'h0,        1'b0, 1});
        vecs.push_back('{1, 1'b0, 32'h8,   32'h0,        4'h0, 32'h13579BDF, 1'b0, 1});
        vecs.push_back('{1, 1'b1, 32'h3C,  32'h0F0F0F0F, 4'hF, 32'h0,        1'b0, 1});
        vecs.push_back('{1, 1'b1, 32'h3C,  32'hAABBCCDD, 4'h6, 32'h0,        1'b0, 1});
        vecs.push_back('{1, 1'b0, 32'h3C,  32'h0,        4'h0, 32'h0FBBCC0F, 1'b0, 1});
        vecs.push_back('{1, 1'b0, 32'h40,  32'h0,        4'h0, 32'h0,        1'b1, 1});
        vecs.push_back('{1, 1'b0, 32'h9,   32'h0,        4'h0, 32'h0,        1'b1, 1});

        foreach (vecs[i]) begin
            do_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rdata, err);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_retire_ready", i),
                  32'(vecs[i].sel ? b_req_ready : a_req_ready), 32'd1);
            check($sformatf("v%0d_retire_valid", i),
                  32'(vecs[i].sel ? b_rsp_valid : a_rsp_valid), 32'd0);
        end

        // backpressure: rsp_ready low for 5 cycles, then ce low masks rsp_ready
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0;
        tick();
        a_req_valid = 1'b0;
        guard = 0;
        while (!a_rsp_valid && guard < 20) begin
            tick();
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(a_rsp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", k), a_rsp_rdata, 32'hDEADBEAA);
            check($sformatf("bp%0d_req_ready", k), 32'(a_req_ready), 32'd0);
            tick();
        end
        ce = 1'b0; a_rsp_ready = 1'b1;
        tick();
        check("bp_ce_low_valid", 32'(a_rsp_valid), 32'd1);
        ce = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        check("bp_idle_state", 32'(a_dbg_state), 32'd0);
        check("bp_idle_ready", 32'(a_req_ready), 32'd1);
        check("bp_idle_valid", 32'(a_rsp_valid), 32'd0);

        // ce low for 3 cycles during WAIT stretches latency from 3 to 6
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h20; a_req_be = 4'h0;
        tick();
        a_req_valid = 1'b0;
        lat = 1;
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            lat++;
        end
        ce = 1'b1;
        while (!a_rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("ce_stall_lat", 32'(lat), 32'd6);
        check("ce_stall_rdata", a_rsp_rdata, 32'hCAFEF00D);
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;

        // reset during WAIT of a store abandons it without writing
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20;
        a_req_wdata = 32'hBAD0BAD0; a_req_be = 4'hF;
        tick();
        a_req_valid = 1'b0;
        check("rst_wait_state", 32'(a_dbg_state), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_wait_rsp_valid", 32'(a_rsp_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst_wait_no_rsp%0d", k), 32'(a_rsp_valid), 32'd0);
        end
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rdata, err);
        check("rst_wait_prior_data", rdata, 32'hCAFEF00D);
        check("rst_wait_prior_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
